// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that lends one shared ALU to two requesters.
// Operands are captured on accept; the flags and result are held until the owner takes the response.
module alu_share_ctrl #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [1:0]       r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [1:0]       r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_negative,
    input  logic             alu_carry,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             owner;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             owner_rsp_ready;

    // On a tie the requester that did not win last time gets the ALU.
    always_comb begin
        grant0 = r0_valid & (~r1_valid | last_grant);
        grant1 = r1_valid & (~r0_valid | ~last_grant);
    end

    assign r0_ready        = (state == IDLE) & grant0;
    assign r1_ready        = (state == IDLE) & grant1;
    assign accept          = r0_ready | r1_ready;
    assign owner_rsp_ready = owner ? r1_rsp_ready : r0_rsp_ready;
    assign r0_rsp_valid    = (state == RESP) & ~owner;
    assign r1_rsp_valid    = (state == RESP) & owner;
    assign busy            = (state != IDLE);
    assign alu_a           = a_q;
    assign alu_b           = b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (owner_rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The ALU only sees a real opcode during the single execute cycle.
    always_comb begin
        alu_ctrl = 3'b000;
        if (state == EXEC) begin
            case (op_q)
                OP_ADD:  alu_ctrl = 3'b001;
                OP_AND:  alu_ctrl = 3'b011;
                OP_NAND: alu_ctrl = 3'b101;
                OP_NOR:  alu_ctrl = 3'b110;
                default: alu_ctrl = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            if (accept) begin
                owner      <= r1_ready;
                last_grant <= r1_ready;
                op_q       <= r1_ready ? r1_op : r0_op;
                a_q        <= r1_ready ? r1_a  : r0_a;
                b_q        <= r1_ready ? r1_b  : r0_b;
            end
            // Carry is meaningful only for ADD; logic ops always report it clear.
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_flags  <= {alu_carry & (op_q == OP_ADD), alu_negative, alu_zero};
            end
        end
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer/arbiter that shares the single 18-bit ALU between two requesters (r0, r1).
- Round-robin grant; operands captured on handshake; ALU driven for one cycle; result and flags registered and returned over a per-requester valid/ready response channel.
- Sits between the requesting units (e.g. address/branch logic) and the ALU instance, and owns the ALU's aluControl, a and b inputs.

Parameters:
- WIDTH, 18, datapath width of operands and result (matches ALU).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- r0_valid  in  1  requester 0 has an operation.
- r0_ready  out  1  controller accepts r0 this cycle.
- r0_op  in  2  00 ADD, 01 AND, 10 NAND, 11 NOR.
- r0_a, r0_b  in  WIDTH  operands.
- r0_rsp_valid  out  1  response for r0 available.
- r0_rsp_ready  in  1  r0 consumes response.
- r1_valid, r1_ready, r1_op, r1_a, r1_b, r1_rsp_valid, r1_rsp_ready: same as r0, for requester 1.
- rsp_result  out  WIDTH  registered ALU result (shared by both responses).
- rsp_flags  out  3  {carry, negative, zero}, registered.
- alu_ctrl  out  3  to ALU aluControl.
- alu_a, alu_b  out  WIDTH  to ALU operands.
- alu_result  in  WIDTH  from ALU.
- alu_zero, alu_negative, alu_carry  in  1  ALU flags.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, async): state=IDLE; last_grant=1 (r0 wins first tie); op/operand regs=0; rsp_result=0; rsp_flags=0; both rsp_valid=0; owner=0; alu_ctrl=000; busy=0.
- FSM states IDLE, EXEC, RESP; one operation outstanding at a time.
- IDLE:
  - Grant is combinational from the valids.
  - If only one requester is valid, it is granted.
  - If both are valid, grant goes to the requester not equal to last_grant.
  - rX_ready = (state==IDLE) & grant==X; at most one ready is high.
  - On handshake: latch op, a, b and owner=X; last_grant=X; go to EXEC.
  - With no valids, stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_ctrl is decoded from the latched op: 00→001, 01→011, 10→101, 11→110.
  - alu_a/alu_b come from the operand regs.
  - At the clock edge: rsp_result←alu_result, rsp_flags←{alu_carry,alu_negative,alu_zero}; go to RESP.
  - In every other state alu_ctrl=000 and alu_a/alu_b hold the last latched operands.
- RESP:
  - r<owner>_rsp_valid=1; the other requester's rsp_valid=0.
  - rsp_result/rsp_flags stay stable until handshake.
  - On r<owner>_rsp_ready: go to IDLE, and rsp_valid drops the next cycle.
  - The non-owner's rsp_ready is ignored.
  - Any wait length is allowed.
- Latency: handshake at cycle N → rsp_valid at N+2. Minimum issue interval is 3 cycles when rsp_ready is held high.
- Operands are registered, so requesters may change rX_a/rX_b/rX_op freely after their ready handshake.
- A requester may hold valid while its own response is pending; it is not re-granted until the FSM returns to IDLE.
- Fairness: with both valids held high continuously, grants strictly alternate.
- Width: ADD carry is bit WIDTH of a+b. Logic ops return carry=0. Zero and negative come from the ALU unmodified.
- Reset mid-operation (EXEC or RESP): the operation is dropped with no response, and all outputs return to their reset values immediately.

Test Plan:
- Reset then r0 ADD a=0x1FFFF, b=0x00001 → r0_ready the same cycle; r0_rsp_valid 2 cycles later; result=0x20000, flags carry=0, neg=1, zero=0.
- r1 ADD a=0x3FFFF, b=0x00001 → result=0x00000, carry=1, zero=1, neg=0; only r1_rsp_valid is high.
- Both valid continuously after reset with ops AND/NOR and rsp_ready=1 → grant order r0,r1,r0,r1; a new accept every 3 cycles; NOR a=0,b=0 → 0x3FFFF, neg=1; alu_ctrl seen as 011/110 in EXEC only.
- r0 NAND a=0x3FFFF, b=0x3FFFF with r0_rsp_ready held low 5 cycles → rsp_valid and result=0x00000 (zero=1) held stable; r1_valid ignored (r1_ready=0) until 1 cycle after the r0 response handshake.
- rst_n asserted during EXEC, then during RESP → rsp_valid=0 and busy=0 immediately; no response delivered; the next request after release is served normally with r0 priority.
- Operands changed the cycle after handshake → response reflects the latched values, not the new ones.
